// File: rtl/khazad_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : khazad_bridge_pkg
// Purpose  : Shared types, write-select codes and word-count helpers for the
//            KHAZAD PS/PL word bridge.
// Revision : 1.0  initial release
// ============================================================================
package khazad_bridge_pkg;

    // Bridge operating states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_BUSY   = 2'd2,
        ST_UNLOAD = 2'd3
    } state_t;

    // wr_sel target codes
    localparam logic [1:0] c_sel_data = 2'b00;
    localparam logic [1:0] c_sel_key  = 2'b01;
    localparam logic [1:0] c_sel_iv   = 2'b10;
    localparam logic [1:0] c_sel_rsvd = 2'b11;

    // Number of bus words making up a wide register
    function automatic int words_of(input int tot_w, input int bus_w);
        return tot_w / bus_w;
    endfunction

    // True when a wide register is a whole, non-zero number of bus words
    function automatic bit is_whole_words(input int tot_w, input int bus_w);
        return (bus_w > 0) && (tot_w >= bus_w) && ((tot_w % bus_w) == 0);
    endfunction

endpackage : khazad_bridge_pkg
`default_nettype wire

// File: rtl/khazad_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : khazad_word_packer
// Purpose  : Shifts BUS_W-bit words into a TOT_W-bit register MSB-word first,
//            counts words and flags a complete register. A parallel load port
//            lets the owner overwrite the whole register (used for chaining).
// Revision : 1.0  initial release
// ============================================================================
module khazad_word_packer
    import khazad_bridge_pkg::*;
#(
    parameter int TOT_W = 64,
    parameter int BUS_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift_en,
    input  logic [BUS_W-1:0] word_in,
    input  logic             load,
    input  logic [TOT_W-1:0] load_data,
    output logic [TOT_W-1:0] data,
    output logic [TOT_W-1:0] data_nxt,
    output logic             full,
    output logic             last
);

    localparam int WORDS = words_of(TOT_W, BUS_W);
    localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [TOT_W-1:0] r_sr;
    logic [CW-1:0]    r_cnt;
    logic             r_full;

    // Register value after shifting in the current word
    generate
        if (TOT_W == BUS_W) begin : g_single_word
            assign data_nxt = word_in;
        end else begin : g_multi_word
            assign data_nxt = {r_sr[TOT_W-BUS_W-1:0], word_in};
        end
    endgenerate

    assign last = shift_en && (r_cnt == CW'(WORDS - 1));
    assign data = r_sr;
    assign full = r_full;

    // Shift/count: the completing word sets full, any other word clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr   <= '0;
            r_cnt  <= '0;
            r_full <= 1'b0;
        end else if (clr) begin
            r_cnt  <= '0;
            r_full <= 1'b0;
        end else if (shift_en) begin
            r_sr <= data_nxt;
            if (last) begin
                r_cnt  <= '0;
                r_full <= 1'b1;
            end else begin
                r_cnt  <= r_cnt + CW'(1);
                r_full <= 1'b0;
            end
        end else if (load) begin
            r_sr <= load_data;
        end
    end

endmodule : khazad_word_packer
`default_nettype wire

// File: rtl/khazad_word_bridge.sv
`default_nettype none
// ============================================================================
// Module   : khazad_word_bridge
// Purpose  : Assembles key and data block from PS bus words, launches the
//            KHAZAD core, and returns the result as bus words.
//            Optional CBC chaining when KHAZAD_BRIDGE_CBC_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module khazad_word_bridge
    import khazad_bridge_pkg::*;
#(
    parameter int BUS_W = 32,
    parameter int KEY_W = 128,
    parameter int BLK_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [1:0]       wr_sel,
    input  logic [BUS_W-1:0] wr_data,
    output logic             wr_ready,
    output logic             key_loaded,
    output logic [KEY_W-1:0] k_in,
    output logic [BLK_W-1:0] d_in,
    output logic             core_start,
    input  logic             core_done,
    input  logic [BLK_W-1:0] d_out,
    output logic             rd_valid,
    input  logic             rd_en,
    output logic [BUS_W-1:0] rd_data,
    output logic             busy,
    output logic             err,
    input  logic             err_clr
);

    localparam int KEY_WORDS = words_of(KEY_W, BUS_W);
    localparam int BLK_WORDS = words_of(BLK_W, BUS_W);
    localparam int RC_W      = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;

    generate
        if (!is_whole_words(KEY_W, BUS_W)) begin : g_bad_key_w
            $error("KEY_W must be a whole multiple of BUS_W");
        end
        if (!is_whole_words(BLK_W, BUS_W)) begin : g_bad_blk_w
            $error("BLK_W must be a whole multiple of BUS_W");
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_start;
    logic [BLK_W-1:0] r_d_in;
    logic [BLK_W-1:0] r_out_sr;
    logic [BLK_W-1:0] w_out_shift;
    logic [RC_W-1:0]  r_rd_cnt;
    logic             r_err;

    logic             w_wr_acc, w_key_wr, w_blk_wr;
    logic             w_blk_last, w_launch, w_drop, w_done;
    logic             w_rd_acc, w_rd_last, w_iv_err, w_err_evt;
    logic [BLK_W-1:0] w_blk_nxt, w_blk_data, w_chain;
    logic [KEY_W-1:0] w_key_nxt;
    logic             w_key_last, w_blk_full;

    assign w_wr_acc  = wr_en && wr_ready;
    assign w_key_wr  = w_wr_acc && (wr_sel == c_sel_key);
    assign w_blk_wr  = w_wr_acc && (wr_sel == c_sel_data);
    // A completed block launches only if a full key is already present
    assign w_launch  = w_blk_last && key_loaded;
    assign w_drop    = w_blk_last && !key_loaded;
    assign w_done    = (r_state == ST_BUSY) && core_done;
    assign w_rd_acc  = rd_en && rd_valid;
    assign w_rd_last = w_rd_acc && (r_rd_cnt == RC_W'(BLK_WORDS - 1));

    khazad_word_packer #(.TOT_W(KEY_W), .BUS_W(BUS_W)) u_key_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (1'b0),
        .shift_en  (w_key_wr),
        .word_in   (wr_data),
        .load      (1'b0),
        .load_data ('0),
        .data      (k_in),
        .data_nxt  (w_key_nxt),
        .full      (key_loaded),
        .last      (w_key_last)
    );

    khazad_word_packer #(.TOT_W(BLK_W), .BUS_W(BUS_W)) u_blk_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (w_drop),
        .shift_en  (w_blk_wr),
        .word_in   (wr_data),
        .load      (1'b0),
        .load_data ('0),
        .data      (w_blk_data),
        .data_nxt  (w_blk_nxt),
        .full      (w_blk_full),
        .last      (w_blk_last)
    );

`ifdef KHAZAD_BRIDGE_CBC_EN
    logic             w_iv_wr;
    logic [BLK_W-1:0] w_iv_nxt;
    logic             w_iv_full, w_iv_last;
    logic             w_unused;

    assign w_iv_wr  = w_wr_acc && (wr_sel == c_sel_iv);
    assign w_iv_err = 1'b0;

    // Chain register: IV words shift in; each result becomes the next IV
    khazad_word_packer #(.TOT_W(BLK_W), .BUS_W(BUS_W)) u_iv_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (1'b0),
        .shift_en  (w_iv_wr),
        .word_in   (wr_data),
        .load      (w_done),
        .load_data (d_out),
        .data      (w_chain),
        .data_nxt  (w_iv_nxt),
        .full      (w_iv_full),
        .last      (w_iv_last)
    );

    assign w_unused = &{1'b0, w_key_nxt, w_key_last, w_blk_data, w_blk_full,
                        w_iv_nxt, w_iv_full, w_iv_last};
`else
    logic w_unused;

    // ECB only: no chain register, IV writes are a protocol error
    assign w_chain  = '0;
    assign w_iv_err = wr_en && (wr_sel == c_sel_iv);
    assign w_unused = &{1'b0, w_key_nxt, w_key_last, w_blk_data, w_blk_full};
`endif

    assign w_err_evt = (wr_en && !wr_ready)
                     || (wr_en && (wr_sel == c_sel_rsvd))
                     || w_iv_err
                     || (rd_en && !rd_valid)
                     || w_drop;

    generate
        if (BLK_W == BUS_W) begin : g_out_single
            assign w_out_shift = '0;
        end else begin : g_out_multi
            assign w_out_shift = {r_out_sr[BLK_W-BUS_W-1:0], {BUS_W{1'b0}}};
        end
    endgenerate

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_LOAD: begin
                if (w_launch) begin
                    w_state_nxt = ST_BUSY;
                end else if (w_drop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_blk_wr) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_BUSY: begin
                if (core_done) begin
                    w_state_nxt = ST_UNLOAD;
                end
            end
            ST_UNLOAD: begin
                if (w_rd_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        wr_ready = 1'b0;
        busy     = 1'b0;
        rd_valid = 1'b0;
        case (r_state)
            ST_IDLE, ST_LOAD: wr_ready = 1'b1;
            ST_BUSY:          busy     = 1'b1;
            ST_UNLOAD:        rd_valid = 1'b1;
            default:          wr_ready = 1'b0;
        endcase
    end

    // Launch: register the (optionally chained) block and pulse start once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start <= 1'b0;
            r_d_in  <= '0;
        end else begin
            r_start <= w_launch;
            if (w_launch) begin
                r_d_in <= w_blk_nxt ^ w_chain;
            end
        end
    end

    // Result capture and word-by-word readout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_sr <= '0;
            r_rd_cnt <= '0;
        end else if (w_done) begin
            r_out_sr <= d_out;
            r_rd_cnt <= '0;
        end else if (w_rd_acc) begin
            r_out_sr <= w_out_shift;
            r_rd_cnt <= w_rd_last ? '0 : (r_rd_cnt + RC_W'(1));
        end
    end

    // Sticky error; a new error beats a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_err_evt) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign core_start = r_start;
    assign d_in       = r_d_in;
    assign rd_data    = r_out_sr[BLK_W-1 -: BUS_W];
    assign err        = r_err;

endmodule : khazad_word_bridge
`default_nettype wire

// File: tb/tb_khazad_word_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_khazad_word_bridge
// Purpose  : Self-checking bench for khazad_word_bridge: queue-based model
//            compared every cycle, a stand-in KHAZAD core, and directed
//            vectors with literal expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_khazad_word_bridge;

    localparam int BUS_W = 32;
    localparam int KEY_W = 128;
    localparam int BLK_W = 64;
    localparam int KW    = KEY_W / BUS_W;
    localparam int BW    = BLK_W / BUS_W;
    localparam logic [127:0] KEY1 = 128'h80000000_00000000_00000000_00000000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_en = 1'b0;
    logic [1:0]       wr_sel = 2'b00;
    logic [BUS_W-1:0] wr_data = '0;
    logic             wr_ready;
    logic             key_loaded;
    logic [KEY_W-1:0] k_in;
    logic [BLK_W-1:0] d_in;
    logic             core_start;
    logic             core_done = 1'b0;
    logic [BLK_W-1:0] d_out = '0;
    logic             rd_valid;
    logic             rd_en = 1'b0;
    logic [BUS_W-1:0] rd_data;
    logic             busy;
    logic             err;
    logic             err_clr = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int n_starts = 0;

    khazad_word_bridge #(.BUS_W(BUS_W), .KEY_W(KEY_W), .BLK_W(BLK_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .key_loaded (key_loaded),
        .k_in       (k_in),
        .d_in       (d_in),
        .core_start (core_start),
        .core_done  (core_done),
        .d_out      (d_out),
        .rd_valid   (rd_valid),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .busy       (busy),
        .err        (err),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stand-in core: fixed KHAZAD vector for the reference key/zero block
    function automatic logic [63:0] core_fn(input logic [63:0] d, input logic [127:0] k);
        if (k == KEY1 && d == 64'h0) return 64'h49A4CE32AC190E3F;
        return {d[31:0], d[63:32]} ^ k[63:0] ^ 64'h0123456789ABCDEF;
    endfunction

    // Core answers 10 cycles after start; it keeps running across bridge reset
    int          core_cnt = 0;
    logic [63:0] core_res = '0;
    always @(posedge clk) begin
        core_done <= 1'b0;
        if (core_start === 1'b1) begin
            n_starts++;
            core_cnt = 10;
            core_res = core_fn(d_in, k_in);
        end else if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
                core_done <= 1'b1;
                d_out     <= core_res;
            end
        end
    end

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 holding data words, 2 core running, 3 result readable
    bit [31:0]    m_key_q[$];
    bit [31:0]    m_blk_q[$];
    bit [31:0]    m_rd_q[$];
    logic [127:0] m_ksr = '0;
    logic [63:0]  m_din = '0;
    logic [63:0]  m_chain = '0;
    int           m_phase = 0;
    bit           m_loaded = 0;
    bit           m_err = 0;
    bit           m_start = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_key_q.delete();
            m_blk_q.delete();
            m_rd_q.delete();
            m_ksr    = '0;
            m_din    = '0;
            m_chain  = '0;
            m_phase  = 0;
            m_loaded = 0;
            m_err    = 0;
            m_start  = 0;
        end else begin
            int          ph;
            bit          ev;
            logic [63:0] blk;
            ph      = m_phase;
            ev      = 0;
            m_start = 0;
            if (wr_en) begin
                if (ph >= 2) begin
                    ev = 1;
                end else begin
                    case (wr_sel)
                        2'b01: begin
                            m_key_q.push_back(wr_data);
                            m_ksr    = {m_ksr[95:0], wr_data};
                            m_loaded = 0;
                            if (m_key_q.size() == KW) begin
                                m_loaded = 1;
                                m_key_q.delete();
                            end
                        end
                        2'b00: begin
                            m_blk_q.push_back(wr_data);
                            m_phase = 1;
                            if (m_blk_q.size() == BW) begin
                                blk = '0;
                                foreach (m_blk_q[i]) blk = (blk << 32) | 64'(m_blk_q[i]);
                                m_blk_q.delete();
                                if (m_loaded) begin
                                    m_din   = blk ^ m_chain;
                                    m_start = 1;
                                    m_phase = 2;
                                end else begin
                                    ev      = 1;
                                    m_phase = 0;
                                end
                            end
                        end
                        2'b10: begin
`ifdef KHAZAD_BRIDGE_CBC_EN
                            m_chain = (m_chain << 32) | 64'(wr_data);
`else
                            ev = 1;
`endif
                        end
                        default: ev = 1;
                    endcase
                end
            end
            if (rd_en) begin
                if (ph != 3) begin
                    ev = 1;
                end else begin
                    void'(m_rd_q.pop_front());
                    if (m_rd_q.size() == 0) m_phase = 0;
                end
            end
            if (core_done && ph == 2) begin
                for (int i = BW - 1; i >= 0; i--) m_rd_q.push_back(d_out[i*32 +: 32]);
                m_phase = 3;
`ifdef KHAZAD_BRIDGE_CBC_EN
                m_chain = d_out;
`endif
            end
            if (ev) m_err = 1;
            else if (err_clr) m_err = 0;
        end
    end

    // Every-cycle comparison against the model, mid-cycle
    always @(negedge clk) begin
        chk("wr_ready",   wr_ready,   m_phase < 2);
        chk("busy",       busy,       m_phase == 2);
        chk("rd_valid",   rd_valid,   m_phase == 3);
        chk("rd_data",    rd_data,    (m_phase == 3) ? m_rd_q[0] : 32'h0);
        chk("key_loaded", key_loaded, m_loaded);
        chk("k_in",       k_in,       m_ksr);
        chk("d_in",       d_in,       m_din);
        chk("core_start", core_start, m_start);
        chk("err",        err,        m_err);
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_data = data;
        cyc();
        wr_en   = 1'b0;
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        chk("err_cleared", err, 1'b0);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 40 && rd_valid !== 1'b1; i++) cyc();
        chk("rd_valid_wait", rd_valid, 1'b1);
    endtask

    task automatic load_key1();
        wr(2'b01, 32'h80000000);
        wr(2'b01, 32'h00000000);
        wr(2'b01, 32'h00000000);
        wr(2'b01, 32'h00000000);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        int s0;
        logic [63:0] r1;

        // Reset state
        cyc();
        cyc();
        chk("rst_wr_ready", wr_ready, 1'b1);
        chk("rst_k_in", k_in, 128'h0);
        chk("rst_err", err, 1'b0);
        rst = 1'b0;
        cyc();

        // Data without key: dropped, error, no start
        s0 = n_starts;
        wr(2'b00, 32'h11111111);
        chk("nokey_busy", busy, 1'b0);
        wr(2'b00, 32'h22222222);
        chk("nokey_err", err, 1'b1);
        chk("nokey_start", core_start, 1'b0);
        chk("nokey_idle", wr_ready, 1'b1);
        cyc();
        chk("nokey_nstarts", n_starts - s0, 0);
        clear_err();

        // Reserved select and read-while-empty errors; error beats clear
        wr_en = 1'b1; wr_sel = 2'b11; wr_data = 32'h0; err_clr = 1'b1;
        cyc();
        wr_en = 1'b0; err_clr = 1'b0;
        chk("rsvd_vs_clr_err", err, 1'b1);
        clear_err();
        rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
        chk("rd_empty_err", err, 1'b1);
        clear_err();
`ifndef KHAZAD_BRIDGE_CBC_EN
        wr(2'b10, 32'h0000000F);
        chk("iv_ecb_err", err, 1'b1);
        clear_err();
`endif

        // Reference vector
        load_key1();
        chk("kv_loaded", key_loaded, 1'b1);
        chk("kv_k_in", k_in, KEY1);
        s0 = n_starts;
        wr(2'b00, 32'h0);
        chk("kv_no_start_yet", core_start, 1'b0);
        wr(2'b00, 32'h0);
        chk("kv_start", core_start, 1'b1);
        chk("kv_busy", busy, 1'b1);
        wr(2'b00, 32'hDEADBEEF);
        chk("busy_wr_ready", wr_ready, 1'b0);
        chk("busy_wr_err", err, 1'b1);
        chk("busy_d_in", d_in, 64'h0);
        clear_err();
        wait_valid();
        chk("kv_nstarts", n_starts - s0, 1);
        chk("kv_rd0", rd_data, 32'h49A4CE32);
        rd_en = 1'b1;
        cyc();
        chk("kv_rd1", rd_data, 32'hAC190E3F);
        cyc();
        rd_en = 1'b0;
        chk("kv_rd_done", rd_valid, 1'b0);
        chk("kv_idle", wr_ready, 1'b1);

        // Key reload half-way: key invalid, completed block dropped
        wr(2'b01, 32'h80000000);
        wr(2'b01, 32'h00000000);
        chk("reload_unloaded", key_loaded, 1'b0);
        s0 = n_starts;
        wr(2'b00, 32'h0);
        wr(2'b00, 32'h0);
        chk("reload_err", err, 1'b1);
        chk("reload_start", core_start, 1'b0);
        cyc();
        chk("reload_nstarts", n_starts - s0, 0);
        clear_err();

        // Reset while the core runs: result is ignored
        wr(2'b01, 32'h00000000);
        wr(2'b01, 32'h00000000);
        chk("abort_loaded", key_loaded, 1'b1);
        wr(2'b00, 32'h0);
        wr(2'b00, 32'h0);
        chk("abort_start", core_start, 1'b1);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        repeat (15) cyc();
        chk("abort_rd_valid", rd_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_k_in", k_in, 128'h0);
        chk("abort_d_in", d_in, 64'h0);
        chk("abort_rd_data", rd_data, 32'h0);
        chk("abort_key_loaded", key_loaded, 1'b0);

`ifdef KHAZAD_BRIDGE_CBC_EN
        // CBC: IV folds into the first block, result into the second
        load_key1();
        wr(2'b10, 32'h0000000F);
        wr(2'b10, 32'h0000000F);
        wr(2'b00, 32'h0);
        wr(2'b00, 32'h0);
        chk("cbc_d_in0", d_in, 64'h0000000F_0000000F);
        r1 = core_fn(64'h0000000F_0000000F, KEY1);
        wait_valid();
        rd_en = 1'b1;
        cyc();
        cyc();
        rd_en = 1'b0;
        wr(2'b00, 32'h0);
        wr(2'b00, 32'h0);
        chk("cbc_d_in1", d_in, r1);
        wait_valid();
        rd_en = 1'b1;
        cyc();
        cyc();
        rd_en = 1'b0;
`else
        r1 = '0;
`endif
        repeat (3) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_khazad_word_bridge
`default_nettype wire
